img_mem_arbiter: RTL and testbench
==================================

// Module: img_mem_arbiter
// PURPOSE
// - Shares the single-port 64 KiB greyscale image RAM between two requesters.
//   - Display fetch path: fixed priority, one read per pixel inside the image window.
//   - Loader write stream: valid/ready handshake.
// - Sits between the timing generator (x/y), the image RAM and the image generator's colour mux.
// - A frame-aligned FSM confines writes to vertical blanking (no tearing) unless TEAR_OK is set.
//   In that case writes also use free active-video cycles.
// PARAMETERS
// - IX_OFFSET  20   image window left edge, pixels
// - IY_OFFSET  20   image window top edge, lines
// - V_ACTIVE   480  first line of vertical blanking (y_i >= V_ACTIVE is vblank)
// - TEAR_OK    0    1: writes also granted in active video when no display read is pending
// PORTS
// - clk_i        in   1        pixel clock
// - rst_i        in   1        synchronous reset, active-high
// - x_i          in   X_POS_W  current pixel column (dvi_pkg)
// - y_i          in   Y_POS_W  current pixel line (dvi_pkg)
// - wr_valid_i   in   1        loader write request
// - wr_addr_i    in   16       loader write address, {row[7:0], col[7:0]}
// - wr_data_i    in   8        loader write pixel
// - wr_ready_o   out  1        write accepted this cycle when wr_valid_i && wr_ready_o
// - mem_we_o     out  1        RAM write enable
// - mem_addr_o   out  16       RAM address
// - mem_wdata_o  out  8        RAM write data
// - mem_rdata_i  in   8        RAM read data, valid 1 cycle after address
// - pix_o        out  8        image pixel to colour mux
// - pix_valid_o  out  1        pix_o belongs to the image window
// - wr_cnt_o     out  17       writes accepted in the last completed vblank period, saturating
// - commit_o     out  1        1-cycle pulse at vblank end if wr_cnt_o > 0
// BEHAVIOUR
// - Window: IX_OFFSET < x_i < IX_OFFSET+256 and IY_OFFSET < y_i < IY_OFFSET+256 (strict bounds).
// - Display read: in a window cycle, mem_addr_o = ((y_i-IY_OFFSET)<<8) + (x_i-IX_OFFSET), 16-bit, mem_we_o=0.
//   - Display read wins unconditionally; wr_ready_o=0 that cycle.
// - Read latency: pix_o / pix_valid_o registered from mem_rdata_i.
//   - Valid 2 cycles after the x_i/y_i that produced the address.
//   - pix_o holds its last value when pix_valid_o=0.
// - wr_ready_o is combinational from state, x_i and y_i only; it never depends on wr_valid_i.
// - Transfer on wr_valid_i && wr_ready_o, same cycle:
//   - mem_we_o=1, mem_addr_o=wr_addr_i, mem_wdata_o=wr_data_i.
//   - Loader holds addr/data stable while valid && !ready.
// - FSM (typedef in dvi_pkg):
//   - S_IDLE: entered on reset; wr_ready_o=0; -> S_VBLANK on the first cycle with y_i >= V_ACTIVE.
//     Never starts mid-frame.
//   - S_VBLANK: wr_ready_o=1 every cycle; -> S_ACTIVE when y_i < V_ACTIVE (frame wrap).
//     On that transition: wr_cnt_o <= count, commit_o=1 if count>0, internal count cleared.
//   - S_ACTIVE: wr_ready_o = TEAR_OK && !window; -> S_VBLANK when y_i >= V_ACTIVE.
//     Writes here add to the count reported at the next vblank end.
// - Internal count: +1 per transfer, saturates at 17'h1FFFF, no wrap.
// - Idle cycles (no read, no write): mem_we_o=0, mem_addr_o=0.
// - Reset values: wr_ready_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, pix_o=0, pix_valid_o=0,
//   wr_cnt_o=0, commit_o=0, state=S_IDLE.
// - Reset mid-transfer: the write is not performed, count is lost, next acceptance waits for vblank.
// - Simultaneous frame wrap and transfer: the transfer is counted in the period it occurred.
//   A vblank write on the last vblank cycle goes into the reported count.
// STRUCTURE
// - dvi_pkg additions: IMG_RES=256, IMG_ADDR_W=16, V_ACTIVE, arb_state_t {S_IDLE,S_VBLANK,S_ACTIVE}.
// - Sub-module img_window_decode: x_i/y_i -> in_window, read address.
//   Shared with the image generator so both use identical window bounds.
// - Arbiter keeps FSM, counter and output registers.
// TESTING
// - Reset at y_i=100, wr_valid_i=1 held -> wr_ready_o=0 until y_i reaches 480, then 1 from that cycle.
// - Window pixel x_i=21,y_i=21 -> mem_addr_o=16'h0101, mem_we_o=0; mem_rdata_i=8'hA5 -> pix_o=8'hA5 two cycles later.
// - TEAR_OK=0, valid held through active video -> no transfer until y_i=480.
//   First vblank cycle writes wr_addr_i/wr_data_i exactly once.
// - TEAR_OK=1, write at x_i=300,y_i=10 -> accepted; at x_i=100,y_i=100 -> stalled, RAM shows display read.
// - 10 vblank writes -> at first y_i<480 cycle: commit_o pulses 1 cycle, wr_cnt_o=10.
//   A frame with 0 writes -> no pulse, wr_cnt_o=0.
// - Continuous valid through vblank of 45 lines x 800 -> wr_cnt_o=36000.
//   Force count near 17'h1FFFF -> saturates, no wrap.

Source files
------------

// File: rtl/dvi_pkg.sv
// dvi_pkg: shared DVI/image constants, the image-RAM arbiter state type and
// a saturating increment helper.
//   X_POS_W / Y_POS_W : widths of the timing generator's pixel/line counters
//   IMG_RES           : image edge length in pixels (square image)
//   IMG_ADDR_W        : image RAM address width, {row[7:0], col[7:0]}
//   V_ACTIVE          : first line of vertical blanking
//   WR_CNT_W          : width of the loader write counter
package dvi_pkg;

    localparam int unsigned X_POS_W    = 10;
    localparam int unsigned Y_POS_W    = 10;
    localparam int unsigned IMG_RES    = 256;
    localparam int unsigned IMG_ADDR_W = 16;
    localparam int unsigned V_ACTIVE   = 480;
    localparam int unsigned WR_CNT_W   = 17;

    typedef enum logic [1:0] {
        S_IDLE,
        S_VBLANK,
        S_ACTIVE
    } arb_state_t;

    // +1 when inc is set, sticking at all-ones instead of wrapping.
    function automatic logic [WR_CNT_W-1:0] sat_inc(input logic [WR_CNT_W-1:0] value,
                                                    input logic                inc);
        if (inc && (value != '1)) begin
            return value + WR_CNT_W'(1);
        end
        return value;
    endfunction

endpackage

// File: rtl/img_window_decode.sv
// img_window_decode: maps the current raster position to the image window
// and to the image RAM read address. Shared with the image generator so
// both sides agree on the exact window bounds.
//   x         in  X_POS_W     current pixel column
//   y         in  Y_POS_W     current pixel line
//   in_window out 1           position lies strictly inside the window
//   rd_addr   out IMG_ADDR_W  {y - IY_OFFSET, x - IX_OFFSET}, low 8 bits each
module img_window_decode
    import dvi_pkg::*;
#(
    parameter int unsigned IX_OFFSET = 20,
    parameter int unsigned IY_OFFSET = 20
) (
    input  logic [X_POS_W-1:0]    x,
    input  logic [Y_POS_W-1:0]    y,
    output logic                  in_window,
    output logic [IMG_ADDR_W-1:0] rd_addr
);

    localparam logic [X_POS_W-1:0] X_LO  = X_POS_W'(IX_OFFSET);
    localparam logic [X_POS_W-1:0] X_HI  = X_POS_W'(IX_OFFSET + IMG_RES);
    localparam logic [Y_POS_W-1:0] Y_LO  = Y_POS_W'(IY_OFFSET);
    localparam logic [Y_POS_W-1:0] Y_HI  = Y_POS_W'(IY_OFFSET + IMG_RES);
    localparam logic [7:0]         X_LO8 = 8'(IX_OFFSET);
    localparam logic [7:0]         Y_LO8 = 8'(IY_OFFSET);

    logic [7:0] col;
    logic [7:0] row;

    assign in_window = (x > X_LO) && (x < X_HI) && (y > Y_LO) && (y < Y_HI);

    // Inside the window both offsets are below 256, so ((y-IY)<<8)+(x-IX)
    // reduces to concatenating the two 8-bit differences.
    assign col     = x[7:0] - X_LO8;
    assign row     = y[7:0] - Y_LO8;
    assign rd_addr = {row, col};

endmodule

// File: rtl/img_mem_arbiter.sv
// img_mem_arbiter: shares the single-port image RAM between the display
// fetch path (fixed priority, one read per window pixel) and the loader
// write stream (valid/ready). Writes are confined to vertical blanking
// unless TEAR_OK allows free active-video cycles too.
//   clk_i, rst_i              pixel clock, synchronous active-high reset
//   x_i, y_i                  raster position from the timing generator
//   wr_valid_i/addr_i/data_i  loader write request, wr_ready_o accepts
//   mem_we_o/addr_o/wdata_o   RAM port, mem_rdata_i valid 1 cycle later
//   pix_o, pix_valid_o        image pixel to the colour mux, 2-cycle latency
//   wr_cnt_o, commit_o        writes of the last completed period + pulse
module img_mem_arbiter
    import dvi_pkg::*;
#(
    parameter int unsigned IX_OFFSET = 20,
    parameter int unsigned IY_OFFSET = 20,
    parameter int unsigned V_ACTIVE  = dvi_pkg::V_ACTIVE,
    parameter bit          TEAR_OK   = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [X_POS_W-1:0]    x_i,
    input  logic [Y_POS_W-1:0]    y_i,
    input  logic                  wr_valid_i,
    input  logic [IMG_ADDR_W-1:0] wr_addr_i,
    input  logic [7:0]            wr_data_i,
    output logic                  wr_ready_o,
    output logic                  mem_we_o,
    output logic [IMG_ADDR_W-1:0] mem_addr_o,
    output logic [7:0]            mem_wdata_o,
    input  logic [7:0]            mem_rdata_i,
    output logic [7:0]            pix_o,
    output logic                  pix_valid_o,
    output logic [WR_CNT_W-1:0]   wr_cnt_o,
    output logic                  commit_o
);

    localparam logic [Y_POS_W-1:0] V_LIM = Y_POS_W'(V_ACTIVE);

    arb_state_t            state;
    logic [WR_CNT_W-1:0]   wr_count;
    logic [WR_CNT_W-1:0]   next_count;
    logic                  in_window;
    logic [IMG_ADDR_W-1:0] rd_addr;
    logic                  vblank_line;
    logic                  xfer;
    logic                  win_d;

    img_window_decode #(
        .IX_OFFSET(IX_OFFSET),
        .IY_OFFSET(IY_OFFSET)
    ) u_window (
        .x        (x_i),
        .y        (y_i),
        .in_window(in_window),
        .rd_addr  (rd_addr)
    );

    assign vblank_line = (y_i >= V_LIM);

    // The port opens on the first blanking line itself, before the state
    // register has caught up, so IDLE/ACTIVE also accept once y_i reaches
    // V_ACTIVE. VBLANK stays open on the wrap cycle so a last-cycle write
    // lands in the period being reported.
    always_comb begin
        wr_ready_o = 1'b0;
        if (!rst_i && !in_window) begin
            if (vblank_line) begin
                wr_ready_o = 1'b1;
            end else begin
                unique case (state)
                    S_VBLANK: wr_ready_o = 1'b1;
                    S_ACTIVE: wr_ready_o = TEAR_OK;
                    default:  wr_ready_o = 1'b0;
                endcase
            end
        end
    end

    assign xfer       = wr_valid_i && wr_ready_o;
    assign next_count = sat_inc(wr_count, xfer);

    // Display read has absolute priority; idle cycles park the port at 0.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (!rst_i) begin
            if (in_window) begin
                mem_addr_o = rd_addr;
            end else if (xfer) begin
                mem_we_o    = 1'b1;
                mem_addr_o  = wr_addr_i;
                mem_wdata_o = wr_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            wr_count    <= '0;
            wr_cnt_o    <= '0;
            commit_o    <= 1'b0;
            win_d       <= 1'b0;
            pix_o       <= '0;
            pix_valid_o <= 1'b0;
        end else begin
            // RAM data of the previous window address arrives this cycle.
            win_d       <= in_window;
            pix_valid_o <= win_d;
            if (win_d) begin
                pix_o <= mem_rdata_i;
            end

            commit_o <= 1'b0;
            wr_count <= next_count;
            case (state)
                S_IDLE: begin
                    if (vblank_line) state <= S_VBLANK;
                end
                S_VBLANK: begin
                    if (!vblank_line) begin
                        state    <= S_ACTIVE;
                        wr_cnt_o <= next_count;
                        commit_o <= (next_count != '0);
                        wr_count <= '0;
                    end
                end
                S_ACTIVE: begin
                    if (vblank_line) state <= S_VBLANK;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_img_mem_arbiter.sv
// Bench for img_mem_arbiter: one instance with TEAR_OK=0 and one with
// TEAR_OK=1 share the same raster/loader stimulus. A frame-level model
// predicts every output each cycle; directed literal checks pin the model.
module tb_img_mem_arbiter;
    import dvi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  rdata;

    logic        rdy    [2];
    logic        we     [2];
    logic [15:0] maddr  [2];
    logic [7:0]  mwd    [2];
    logic [7:0]  pix    [2];
    logic        pixv   [2];
    logic [16:0] cnt    [2];
    logic        commit [2];

    int checks   = 0;
    int failures = 0;
    int lmode    = 1;   // 0 random valid, 1 valid always, 2 valid never

    img_mem_arbiter #(.IX_OFFSET(20), .IY_OFFSET(20), .V_ACTIVE(480), .TEAR_OK(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .x_i(x), .y_i(y),
        .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ready_o(rdy[0]),
        .mem_we_o(we[0]), .mem_addr_o(maddr[0]), .mem_wdata_o(mwd[0]), .mem_rdata_i(rdata),
        .pix_o(pix[0]), .pix_valid_o(pixv[0]), .wr_cnt_o(cnt[0]), .commit_o(commit[0])
    );

    img_mem_arbiter #(.IX_OFFSET(20), .IY_OFFSET(20), .V_ACTIVE(480), .TEAR_OK(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst), .x_i(x), .y_i(y),
        .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ready_o(rdy[1]),
        .mem_we_o(we[1]), .mem_addr_o(maddr[1]), .mem_wdata_o(mwd[1]), .mem_rdata_i(rdata),
        .pix_o(pix[1]), .pix_valid_o(pixv[1]), .wr_cnt_o(cnt[1]), .commit_o(commit[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    bit       m_prev_blank [2];   // previous cycle was on a blanking line
    bit       m_started    [2];   // a blanking line has been seen since reset
    bit       m_win_d      [2];
    bit       m_pixv       [2];
    bit       m_commit     [2];
    bit [7:0] m_pix        [2];
    int       m_count      [2];
    int       m_cnt_out    [2];

    function automatic int sat_add(input int c, input bit inc);
        return (c + int'(inc) > 32'h1FFFF) ? 32'h1FFFF : c + int'(inc);
    endfunction

    always begin : model_and_compare
        @(negedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            int xi, yi, raddr, exp_addr, total;
            bit win, blank, rdy_e, xfer;
            xi    = int'(x);
            yi    = int'(y);
            win   = (xi > 20) && (xi < 276) && (yi > 20) && (yi < 276);
            blank = (yi >= 480);
            raddr = ((yi - 20) * 256 + (xi - 20)) & 32'hFFFF;
            rdy_e = !rst && !win && (blank || m_prev_blank[i] || (i == 1 && m_started[i]));
            xfer  = rdy_e && wr_valid;
            exp_addr = rst ? 0 : (win ? raddr : (xfer ? int'(wr_addr) : 0));

            check($sformatf("ready[%0d]", i),     32'(rdy[i]),    32'(rdy_e));
            check($sformatf("mem_we[%0d]", i),    32'(we[i]),     32'(xfer));
            check($sformatf("mem_addr[%0d]", i),  32'(maddr[i]),  exp_addr);
            check($sformatf("mem_wdata[%0d]", i), 32'(mwd[i]),    xfer ? 32'(wr_data) : 32'd0);
            check($sformatf("pix[%0d]", i),       32'(pix[i]),    32'(m_pix[i]));
            check($sformatf("pix_valid[%0d]", i), 32'(pixv[i]),   32'(m_pixv[i]));
            check($sformatf("wr_cnt[%0d]", i),    32'(cnt[i]),    m_cnt_out[i]);
            check($sformatf("commit[%0d]", i),    32'(commit[i]), 32'(m_commit[i]));

            if (rst) begin
                m_prev_blank[i] = 0; m_started[i] = 0; m_win_d[i] = 0; m_pixv[i] = 0;
                m_commit[i] = 0; m_pix[i] = 0; m_count[i] = 0; m_cnt_out[i] = 0;
            end else begin
                if (m_prev_blank[i] && !blank) begin
                    total        = sat_add(m_count[i], xfer);
                    m_cnt_out[i] = total;
                    m_commit[i]  = (total != 0);
                    m_count[i]   = 0;
                end else begin
                    m_count[i]  = sat_add(m_count[i], xfer);
                    m_commit[i] = 0;
                end
                if (m_win_d[i]) m_pix[i] = rdata;
                m_pixv[i]       = m_win_d[i];
                m_win_d[i]      = win;
                m_started[i]    = m_started[i] || blank;
                m_prev_blank[i] = blank;
            end
        end
    end

    // ---------------- stimulus ----------------
    // One cycle: loader keeps addr/data/valid while a request to dut0 stalls.
    task automatic step(input int nx, input int ny);
        @(negedge clk);
        if (!(wr_valid && !rdy[0] && lmode != 2)) begin
            wr_addr = 16'($urandom);
            wr_data = 8'($urandom);
            case (lmode)
                0:       wr_valid = ($urandom_range(0, 1) == 1);
                1:       wr_valid = 1'b1;
                default: wr_valid = 1'b0;
            endcase
        end
        x     = 10'(nx);
        y     = 10'(ny);
        rdata = 8'($urandom);
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic rand_active();
        if ($urandom_range(0, 1) == 1) step($urandom_range(15, 280), $urandom_range(15, 280));
        else                           step($urandom_range(0, 799), $urandom_range(0, 479));
    endtask

    logic [15:0] held_addr;
    logic [7:0]  held_data;

    initial begin
        rst = 1'b1; x = 10'd21; y = 10'd100; wr_valid = 1'b1;
        wr_addr = 16'h1234; wr_data = 8'h56; rdata = 8'h00;

        // Reset with valid held and a window position on the inputs.
        for (int k = 0; k < 3; k++) begin
            step(21, 21);
            settle();
            check("rst_ready", 32'(rdy[0]), 32'd0);
            check("rst_addr", 32'(maddr[0]), 32'd0);
        end
        check("rst_pix", 32'(pix[0]), 32'd0);
        check("rst_cnt", 32'(cnt[0]), 32'd0);

        step(300, 100);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(300, 100);
            settle();
            check("idle_ready0", 32'(rdy[0]), 32'd0);
            check("idle_ready1", 32'(rdy[1]), 32'd0);
        end
        step(300, 480);
        settle();
        check("first_vblank_ready", 32'(rdy[0]), 32'd1);
        check("first_vblank_we", 32'(we[0]), 32'd1);
        check("first_vblank_addr", 32'(maddr[0]), 32'h1234);
        check("first_vblank_data", 32'(mwd[0]), 32'h56);
        for (int k = 0; k < 10; k++) step(k, 481);

        // Window read and two-cycle pixel latency.
        lmode = 2;
        step(0, 0);
        step(21, 21);
        settle();
        check("win_addr", 32'(maddr[0]), 32'h0101);
        check("win_we", 32'(we[0]), 32'd0);
        step(22, 21);
        rdata = 8'hA5;
        step(23, 21);
        settle();
        check("win_pix", 32'(pix[0]), 32'hA5);
        check("win_pixv", 32'(pixv[0]), 32'd1);

        // Tear-tolerant instance: free active cycle vs window cycle.
        lmode = 1;
        step(300, 10);
        settle();
        check("tear_ready", 32'(rdy[1]), 32'd1);
        check("tear_we", 32'(we[1]), 32'd1);
        check("notear_ready", 32'(rdy[0]), 32'd0);
        step(100, 100);
        settle();
        check("tear_win_ready", 32'(rdy[1]), 32'd0);
        check("tear_win_we", 32'(we[1]), 32'd0);
        check("tear_win_addr", 32'(maddr[1]), 32'h5050);

        // Valid held through active video: dut0 first writes on line 480.
        for (int k = 0; k < 50; k++) rand_active();
        held_addr = wr_addr;
        held_data = wr_data;
        step(5, 480);
        settle();
        check("held_we", 32'(we[0]), 32'd1);
        check("held_addr", 32'(maddr[0]), 32'(held_addr));
        check("held_data", 32'(mwd[0]), 32'(held_data));
        lmode = 2;
        for (int k = 0; k < 5; k++) step(6 + k, 480);
        step(0, 0);

        // Exactly ten vblank writes.
        for (int k = 0; k < 20; k++) rand_active();
        step(0, 480);
        lmode = 1;
        for (int k = 0; k < 10; k++) step(k, 481);
        lmode = 2;
        for (int k = 0; k < 5; k++) step(20 + k, 481);
        step(0, 0);
        step(1, 0);
        settle();
        check("ten_commit", 32'(commit[0]), 32'd1);
        check("ten_cnt0", 32'(cnt[0]), 32'd10);
        check("ten_cnt1", 32'(cnt[1]), 32'd10);
        step(2, 0);
        settle();
        check("ten_commit_end", 32'(commit[0]), 32'd0);

        // Frame without writes.
        for (int k = 0; k < 10; k++) rand_active();
        for (int k = 0; k < 10; k++) step(k, 490);
        step(0, 0);
        step(1, 0);
        settle();
        check("zero_commit", 32'(commit[0]), 32'd0);
        check("zero_cnt", 32'(cnt[0]), 32'd0);

        // Continuous valid over a full 45 x 800 blanking interval.
        for (int k = 0; k < 10; k++) rand_active();
        lmode = 1;
        for (int yy = 480; yy < 525; yy++)
            for (int xx = 0; xx < 800; xx++) step(xx, yy);
        lmode = 2;
        step(0, 0);
        step(1, 0);
        settle();
        check("full_cnt0", 32'(cnt[0]), 32'd36000);
        check("full_cnt1", 32'(cnt[1]), 32'd36000);
        check("full_commit", 32'(commit[0]), 32'd1);

        // Saturation from a preloaded count.
        step(0, 480);
        step(1, 480);
        force dut0.wr_count = 17'h1FFF0;
        force dut1.wr_count = 17'h1FFF0;
        m_count[0] = 32'h1FFF0;
        m_count[1] = 32'h1FFF0;
        #1;
        release dut0.wr_count;
        release dut1.wr_count;
        lmode = 1;
        for (int k = 0; k < 40; k++) step(k, 481);
        lmode = 2;
        step(0, 0);
        step(1, 0);
        settle();
        check("sat_cnt0", 32'(cnt[0]), 32'h1FFFF);
        check("sat_cnt1", 32'(cnt[1]), 32'h1FFFF);

        // Randomised frames, one with a reset in the middle of blanking.
        lmode = 0;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 300; k++) rand_active();
            for (int k = 0; k < 150; k++) begin
                step($urandom_range(0, 799), $urandom_range(480, 524));
                if (f == 2 && k == 70) rst = 1'b1;
                if (f == 2 && k == 71) rst = 1'b0;
            end
        end
        step(0, 0);
        step(1, 0);
        step(2, 0);
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
